// File: rtl/dcache_dm_pkg.sv
// Shared types for the direct-mapped write-through data cache.
package dcache_dm_pkg;

  typedef enum logic [1:0] {
    DC_IDLE  = 2'd0,
    DC_RFILL = 2'd1,
    DC_WRITE = 2'd2,
    DC_DONE  = 2'd3
  } dc_state_e;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read on one index, synchronous write,
// flash clear of all valid bits. Only the valid bits are reset.
module dcache_array #(
  parameter int DW    = 16,
  parameter int TW    = 12,
  parameter int LINES = 16,
  parameter int IW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_valid,
  input  logic [TW-1:0] wr_tag,
  input  logic [DW-1:0] wr_data,
  input  logic          valid_clr_all
);

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [DW-1:0]    data_mem [LINES];

  // A line write wins over the flash clear; the caller folds flush into wr_valid.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q[gi] <= 1'b0;
        end else if (wr_en && (wr_idx == IW'(gi))) begin
          valid_q[gi] <= wr_valid;
        end else if (valid_clr_all) begin
          valid_q[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// EXE_MEM register and a variable-latency backing memory.
module dcache_dm
  import dcache_dm_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int LINES = 16,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_rd,
  input  logic            cpu_wr,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic [DW-1:0]   cpu_rdata,
  output logic            stall,
  input  logic            flush,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic [CNTW-1:0] hit_cnt,
  output logic [CNTW-1:0] miss_cnt
);

  localparam int IW = $clog2(LINES);
  localparam int TW = AW - IW;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          arr_valid;
  logic [TW-1:0] arr_tag;
  logic [DW-1:0] arr_data;
  logic          hit;
  logic          hit_eff;

  logic          arr_we;
  logic          arr_wvalid;
  logic [DW-1:0] arr_wdata;

  dc_state_e     state_q;
  logic          load_q;
  logic          flushed_q;
  logic [DW-1:0] cpu_rdata_q;
  logic          mem_rd_q;
  logic          mem_wr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [CNTW-1:0] hit_cnt_q;
  logic [CNTW-1:0] miss_cnt_q;

  assign idx     = cpu_addr[IW-1:0];
  assign tag     = cpu_addr[AW-1:IW];
  assign hit     = arr_valid && (arr_tag == tag);
  // A flush in the same cycle makes every lookup a miss.
  assign hit_eff = hit && !flush;

  dcache_array #(
    .DW   (DW),
    .TW   (TW),
    .LINES(LINES),
    .IW   (IW)
  ) u_array (
    .clk          (clk),
    .rst          (rst),
    .rd_idx       (idx),
    .rd_valid     (arr_valid),
    .rd_tag       (arr_tag),
    .rd_data      (arr_data),
    .wr_en        (arr_we),
    .wr_idx       (idx),
    .wr_valid     (arr_wvalid),
    .wr_tag       (tag),
    .wr_data      (arr_wdata),
    .valid_clr_all(flush)
  );

  always_comb begin
    arr_we     = 1'b0;
    arr_wvalid = 1'b0;
    arr_wdata  = cpu_wdata;
    case (state_q)
      DC_RFILL: begin
        if (mem_ready) begin
          arr_we     = 1'b1;
          arr_wvalid = !(flushed_q || flush);
          arr_wdata  = mem_rdata;
        end
      end
      DC_WRITE: begin
        if (mem_ready && hit_eff) begin
          arr_we     = 1'b1;
          arr_wvalid = 1'b1;
          arr_wdata  = cpu_wdata;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    if (rst) begin
      case (state_q)
        DC_IDLE:            stall = cpu_wr || (cpu_rd && !hit_eff);
        DC_RFILL, DC_WRITE: stall = 1'b1;
        default:            stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= DC_IDLE;
      load_q      <= 1'b0;
      flushed_q   <= 1'b0;
      cpu_rdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      case (state_q)
        DC_IDLE: begin
          flushed_q <= 1'b0;
          if (cpu_wr) begin
            state_q     <= DC_WRITE;
            load_q      <= 1'b0;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= cpu_addr;
            mem_wdata_q <= cpu_wdata;
          end else if (cpu_rd) begin
            if (hit_eff) begin
              cpu_rdata_q <= arr_data;
              if (hit_cnt_q != {CNTW{1'b1}}) hit_cnt_q <= hit_cnt_q + CNTW'(1);
            end else begin
              if (miss_cnt_q != {CNTW{1'b1}}) miss_cnt_q <= miss_cnt_q + CNTW'(1);
              state_q    <= DC_RFILL;
              load_q     <= 1'b1;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= cpu_addr;
            end
          end
        end
        DC_RFILL: begin
          if (flush) flushed_q <= 1'b1;
          if (mem_ready) begin
            mem_rd_q <= 1'b0;
            state_q  <= DC_DONE;
          end
        end
        DC_WRITE: begin
          if (mem_ready) begin
            mem_wr_q <= 1'b0;
            state_q  <= DC_DONE;
          end
        end
        DC_DONE: begin
          // The fill already landed in the data array, even if flushed.
          if (load_q) cpu_rdata_q <= arr_data;
          state_q <= DC_IDLE;
        end
        default: state_q <= DC_IDLE;
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm with a 3-cycle backing memory model and a
// small-counter instance for saturation.
module tb_dcache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        flush = 1'b0;
  logic [15:0] cpu_rdata;
  logic        stall;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [15:0] hit_cnt, miss_cnt;

  logic        s_rd = 1'b0;
  logic [15:0] s_addr = '0;
  logic [15:0] s_rdata;
  logic        s_stall, s_mem_rd, s_mem_wr;
  logic [15:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [1:0]  s_hit, s_miss;

  logic [15:0] mem [256];
  logic [1:0]  lat_cnt;
  logic        ready_q;
  logic        fast = 1'b0;

  int total = 0;
  int bad = 0;
  int st_cyc, mrd_cyc, mwr_cyc, n;
  logic [15:0] last_maddr;
  logic [15:0] got_rdata;

  always #5 clk = ~clk;

  dcache_dm dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall), .flush(flush),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  dcache_dm #(.CNTW(2)) dut_s (
    .clk(clk), .rst(rst), .cpu_rd(s_rd), .cpu_wr(1'b0), .cpu_addr(s_addr),
    .cpu_wdata(16'h0000), .cpu_rdata(s_rdata), .stall(s_stall), .flush(1'b0),
    .mem_rd(s_mem_rd), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(s_mem_rdata), .mem_ready(1'b1), .hit_cnt(s_hit), .miss_cnt(s_miss)
  );

  assign s_mem_rdata = s_mem_addr ^ 16'h5A5A;

  // Backing memory: ready in the third cycle of a request, or at once in fast mode.
  assign mem_rdata = mem[mem_addr[7:0]];
  assign mem_ready = fast ? 1'b1 : ready_q;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt <= 2'd0;
      ready_q <= 1'b0;
    end else if (ready_q) begin
      lat_cnt <= 2'd0;
      ready_q <= 1'b0;
    end else if ((mem_rd || mem_wr) && !fast) begin
      if (lat_cnt == 2'd1) ready_q <= 1'b1;
      else lat_cnt <= lat_cnt + 2'd1;
    end
  end

  always @(posedge clk) begin
    if (mem_wr && mem_ready) mem[mem_addr[7:0]] = mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One CPU request held until stall drops, then released after the advancing edge.
  task automatic op(input logic rd, input logic wr, input logic [15:0] a,
                    input logic [15:0] wd, input int fl_at);
    @(negedge clk);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd;
    st_cyc = 0; mrd_cyc = 0; mwr_cyc = 0; n = 0; last_maddr = 16'hxxxx;
    flush = (fl_at == 0);
    #1;
    while (stall && n < 40) begin
      st_cyc++;
      if (mem_rd) begin mrd_cyc++; last_maddr = mem_addr; end
      if (mem_wr) begin mwr_cyc++; last_maddr = mem_addr; end
      @(negedge clk);
      n++;
      flush = (n == fl_at);
      #1;
    end
    chk("no_timeout", 32'(n < 40), 32'd1);
    @(posedge clk);
    #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; flush = 1'b0;
    got_rdata = cpu_rdata;
    $display("op rd=%0b wr=%0b addr=%h stall_cycles=%0d rdata=%h hit=%0d miss=%0d",
             rd, wr, a, st_cyc, got_rdata, hit_cnt, miss_cnt);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);

    #2;
    chk("rst_rdata", 32'(cpu_rdata), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_mem_rd", 32'(mem_rd), 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_hit", 32'(hit_cnt), 32'h0);
    chk("rst_miss", 32'(miss_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // 1: cold miss
    op(1, 0, 16'h0005, 16'h0, -1);
    chk("t1_stall", st_cyc, 4);
    chk("t1_mrd", mrd_cyc, 3);
    chk("t1_maddr", 32'(last_maddr), 32'h0005);
    chk("t1_rdata", 32'(got_rdata), 32'h1005);
    chk("t1_miss", 32'(miss_cnt), 1);
    chk("t1_hit", 32'(hit_cnt), 0);
    chk("t1_mrd_done", 32'(mem_rd), 0);

    // 2: hit
    op(1, 0, 16'h0005, 16'h0, -1);
    chk("t2_stall", st_cyc, 0);
    chk("t2_rdata", 32'(got_rdata), 32'h1005);
    chk("t2_hit", 32'(hit_cnt), 1);

    // 3: conflict misses on index 5
    op(1, 0, 16'h0015, 16'h0, -1);
    chk("t3a_stall", st_cyc, 4);
    chk("t3a_rdata", 32'(got_rdata), 32'h1015);
    op(1, 0, 16'h0005, 16'h0, -1);
    chk("t3b_stall", st_cyc, 4);
    chk("t3b_miss", 32'(miss_cnt), 3);
    op(1, 0, 16'h0015, 16'h0, -1);
    chk("t3c_miss", 32'(miss_cnt), 4);

    // 4: store hit updates line; store miss does not allocate
    op(0, 1, 16'h0015, 16'hBEEF, -1);
    chk("t4_stall", st_cyc, 4);
    chk("t4_mwr", mwr_cyc, 3);
    chk("t4_maddr", 32'(last_maddr), 32'h0015);
    chk("t4_mem", 32'(mem[8'h15]), 32'hBEEF);
    chk("t4_cnt", 32'({hit_cnt, miss_cnt}), 32'h0001_0004);
    op(1, 0, 16'h0015, 16'h0, -1);
    chk("t4_ld_stall", st_cyc, 0);
    chk("t4_ld_rdata", 32'(got_rdata), 32'hBEEF);
    chk("t4_ld_hit", 32'(hit_cnt), 2);
    op(0, 1, 16'h0020, 16'h1234, -1);
    chk("t4_st2_mwr", mwr_cyc, 3);
    op(1, 0, 16'h0020, 16'h0, -1);
    chk("t4_noalloc_stall", st_cyc, 4);
    chk("t4_noalloc_rdata", 32'(got_rdata), 32'h1234);
    chk("t4_noalloc_miss", 32'(miss_cnt), 5);

    // 5: flush
    op(1, 0, 16'h0005, 16'h0, -1);
    chk("t5_miss", 32'(miss_cnt), 6);
    op(1, 0, 16'h0005, 16'h0, -1);
    chk("t5_hit", 32'(hit_cnt), 3);
    op(0, 0, 16'h0005, 16'h0, 0);
    op(1, 0, 16'h0005, 16'h0, -1);
    chk("t5_flushed_stall", st_cyc, 4);
    chk("t5_flushed_miss", 32'(miss_cnt), 7);
    op(1, 0, 16'h0005, 16'h0, 0);
    chk("t5_sameflush_stall", st_cyc, 4);
    chk("t5_sameflush_miss", 32'(miss_cnt), 8);
    op(1, 0, 16'h0015, 16'h0, 2);
    chk("t5_rfflush_rdata", 32'(got_rdata), 32'hBEEF);
    op(1, 0, 16'h0015, 16'h0, -1);
    chk("t5_rfflush_stall", st_cyc, 4);
    chk("t5_rfflush_miss", 32'(miss_cnt), 10);
    op(1, 0, 16'h0015, 16'h0, -1);
    chk("t5_refill_hit", 32'(hit_cnt), 4);

    // 6: reset in the middle of a fill
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 16'h0033;
    @(negedge clk);
    #1;
    chk("t6_mrd_before", 32'(mem_rd), 1);
    rst = 1'b0; cpu_rd = 1'b0;
    #1;
    chk("t6_mrd", 32'(mem_rd), 0);
    chk("t6_stall", 32'(stall), 0);
    chk("t6_cnt", 32'({hit_cnt, miss_cnt}), 32'h0);
    chk("t6_rdata", 32'(cpu_rdata), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    op(1, 0, 16'h0015, 16'h0, -1);
    chk("t6_after_stall", st_cyc, 4);
    chk("t6_after_miss", 32'(miss_cnt), 1);

    fast = 1'b1;
    op(1, 0, 16'h0007, 16'h0, -1);
    chk("t6_fast_stall", st_cyc, 2);
    chk("t6_fast_rdata", 32'(got_rdata), 32'h1007);
    chk("t6_fast_miss", 32'(miss_cnt), 2);
    fast = 1'b0;

    // Saturation on the 2-bit-counter instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_rd = 1'b1; s_addr = 16'h0040 + 16'(i);
      repeat (3) @(posedge clk);
      #1;
      s_rd = 1'b0;
      $display("sat load addr=%h rdata=%h miss=%0d", s_addr, s_rdata, s_miss);
      chk("sat_rdata", 32'(s_rdata), 32'(s_addr ^ 16'h5A5A));
      chk("sat_miss", 32'(s_miss), (i < 3) ? (i + 1) : 3);
    end
    @(negedge clk);
    s_rd = 1'b1; s_addr = 16'h0040;
    @(posedge clk);
    #1;
    s_rd = 1'b0;
    chk("sat_hit", 32'(s_hit), 1);
    chk("sat_idle", 32'({s_stall, s_mem_rd, s_mem_wr}), 0);
    chk("sat_wdata", 32'(s_mem_wdata), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
